// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare predictor update path:
// counter encodings, controller states and the in-flight branch record.
package bp_pkg;

    localparam int unsigned BP_IDX_BITS = 10;
    localparam int unsigned BP_GHR_BITS = 10;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic {
        INIT,
        RUN
    } bp_state_t;

    typedef struct packed {
        logic [BP_IDX_BITS-1:0] idx;
        logic [1:0]             cnt;
        logic                   pred;
        logic [BP_GHR_BITS-1:0] ghr_ckpt;
    } bp_entry_t;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] r;
        r = cnt;
        if (taken) begin
            if (cnt != CNT_ST) r = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) r = cnt - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular buffer of unresolved branch records; head is visible combinationally.
// Flush empties the buffer and wins over a simultaneous push.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  bp_entry_t                  push_data,
    input  logic                       pop,
    input  logic                       flush,
    output bp_entry_t                  head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// gshare GHR owner and branch bookkeeping: index hash at fetch, in-order
// resolution with PHT counter write-back, mispredict recovery and PHT clear.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = BP_IDX_BITS,
    parameter int unsigned GHR_BITS = BP_GHR_BITS,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned XLEN     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                f_branch_valid,
    input  logic [XLEN-1:0]     f_pc,
    output logic                f_pred_taken,
    output logic                f_stall,
    input  logic                ex_resolve_valid,
    input  logic                ex_taken,
    output logic                ex_mispredict,
    output logic                resolve_err,
    output logic                busy_init,
    output logic [IDX_BITS-1:0] pht_rd_idx,
    input  logic [1:0]          pht_rd_cnt,
    output logic                pht_wr_en,
    output logic [IDX_BITS-1:0] pht_wr_idx,
    output logic [1:0]          pht_wr_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    bp_state_t           state_q, state_d;
    logic [IDX_BITS:0]   init_idx_q, init_idx_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    bp_entry_t           push_entry;
    bp_entry_t           head;
    logic                q_full;
    logic                q_empty;
    logic [CNT_W-1:0]    q_count;
    logic                pop_valid;
    logic                mispredict;
    logic                push_accept;
    logic                wr_en_d;
    logic [IDX_BITS-1:0] wr_idx_d;
    logic [1:0]          wr_cnt_d;
    logic                unused_bits;

    assign busy_init    = (state_q == INIT);
    assign f_stall      = busy_init | q_full;
    assign pht_rd_idx   = ghr_q[IDX_BITS-1:0] ^ f_pc[IDX_BITS+1:2];
    assign f_pred_taken = pht_rd_cnt[1];

    assign pop_valid   = ex_resolve_valid & (q_count != '0);
    assign mispredict  = pop_valid & (ex_taken != head.pred);
    assign push_accept = f_branch_valid & ~f_stall & ~mispredict;

    assign push_entry.idx      = pht_rd_idx;
    assign push_entry.cnt      = pht_rd_cnt;
    assign push_entry.pred     = pht_rd_cnt[1];
    assign push_entry.ghr_ckpt = ghr_q;

    assign unused_bits = ^{f_pc[XLEN-1:IDX_BITS+2], f_pc[1:0],
                           ghr_q[GHR_BITS-1], head.ghr_ckpt[GHR_BITS-1]};

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_accept),
        .push_data (push_entry),
        .pop       (pop_valid),
        .flush     (mispredict),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // init_idx carries an extra bit so RUN is entered one cycle after the last clear write.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ghr_d      = ghr_q;
        wr_en_d    = 1'b0;
        wr_idx_d   = pht_wr_idx;
        wr_cnt_d   = pht_wr_cnt;
        unique case (state_q)
            INIT: begin
                if (init_idx_q[IDX_BITS]) begin
                    state_d = RUN;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_idx_d   = init_idx_q[IDX_BITS-1:0];
                    wr_cnt_d   = CNT_WNT;
                    init_idx_d = init_idx_q + (IDX_BITS+1)'(1);
                end
            end
            RUN: begin
                if (pop_valid) begin
                    wr_en_d  = 1'b1;
                    wr_idx_d = head.idx;
                    wr_cnt_d = cnt_update(head.cnt, ex_taken);
                end
            end
            default: state_d = INIT;
        endcase
        if (mispredict)       ghr_d = {head.ghr_ckpt[GHR_BITS-2:0], ex_taken};
        else if (push_accept) ghr_d = {ghr_q[GHR_BITS-2:0], pht_rd_cnt[1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            ghr_q         <= '0;
            pht_wr_en     <= 1'b0;
            pht_wr_idx    <= '0;
            pht_wr_cnt    <= '0;
            ex_mispredict <= 1'b0;
            resolve_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            ghr_q         <= ghr_d;
            pht_wr_en     <= wr_en_d;
            pht_wr_idx    <= wr_idx_d;
            pht_wr_cnt    <= wr_cnt_d;
            ex_mispredict <= mispredict;
            resolve_err   <= resolve_err | (ex_resolve_valid & q_empty);
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed and random checks of bp_update_ctrl against a queue-based
// reference model of the in-flight branches and global history.
module tb_bp_update_ctrl;

    localparam int unsigned IDX_BITS = 10;
    localparam int unsigned GHR_BITS = 10;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned PHT_SIZE = 1 << IDX_BITS;
    localparam int unsigned IDX_MASK = PHT_SIZE - 1;
    localparam int unsigned GHR_MASK = (1 << GHR_BITS) - 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                f_branch_valid;
    logic [XLEN-1:0]     f_pc;
    logic                f_pred_taken;
    logic                f_stall;
    logic                ex_resolve_valid;
    logic                ex_taken;
    logic                ex_mispredict;
    logic                resolve_err;
    logic                busy_init;
    logic [IDX_BITS-1:0] pht_rd_idx;
    logic [1:0]          pht_rd_cnt;
    logic                pht_wr_en;
    logic [IDX_BITS-1:0] pht_wr_idx;
    logic [1:0]          pht_wr_cnt;

    always #5 clk = ~clk;

    bp_update_ctrl #(
        .IDX_BITS (IDX_BITS),
        .GHR_BITS (GHR_BITS),
        .DEPTH    (DEPTH),
        .XLEN     (XLEN)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .f_branch_valid   (f_branch_valid),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .f_stall          (f_stall),
        .ex_resolve_valid (ex_resolve_valid),
        .ex_taken         (ex_taken),
        .ex_mispredict    (ex_mispredict),
        .resolve_err      (resolve_err),
        .busy_init        (busy_init),
        .pht_rd_idx       (pht_rd_idx),
        .pht_rd_cnt       (pht_rd_cnt),
        .pht_wr_en        (pht_wr_en),
        .pht_wr_idx       (pht_wr_idx),
        .pht_wr_cnt       (pht_wr_cnt)
    );

    typedef struct {
        int unsigned idx;
        int unsigned cnt;
        bit          pred;
        int unsigned ckpt;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_ghr;
    bit          m_err;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat_next(input int unsigned c, input bit tk);
        if (tk) return (c >= 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    // One RUN-mode cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic run_cycle(input bit bv, input logic [XLEN-1:0] pc, input logic [1:0] cnt,
                             input bit rv, input bit tk);
        bit          pop, mis, push, full;
        ent_t        head;
        int unsigned exp_idx, exp_cnt;
        f_branch_valid   = bv;
        f_pc             = pc;
        pht_rd_cnt       = cnt;
        ex_resolve_valid = rv;
        ex_taken         = tk;
        #1;
        full    = (mq.size() == DEPTH);
        exp_idx = (m_ghr ^ (pc >> 2)) & IDX_MASK;
        chk("f_stall", f_stall, full);
        chk("pht_rd_idx", pht_rd_idx, exp_idx);
        chk("f_pred_taken", f_pred_taken, cnt[1]);
        pop     = rv && (mq.size() > 0);
        mis     = pop && (tk != mq[0].pred);
        push    = bv && !full && !mis;
        exp_cnt = 0;
        if (pop) begin
            head    = mq[0];
            exp_cnt = sat_next(head.cnt, tk);
        end
        if (rv && mq.size() == 0) m_err = 1'b1;
        if (mis) begin
            m_ghr = ((mq[0].ckpt << 1) | tk) & GHR_MASK;
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{exp_idx, cnt, cnt[1], m_ghr});
                m_ghr = ((m_ghr << 1) | cnt[1]) & GHR_MASK;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_mispredict", ex_mispredict, mis);
        chk("pht_wr_en", pht_wr_en, pop);
        if (pop) begin
            chk("pht_wr_idx", pht_wr_idx, head.idx);
            chk("pht_wr_cnt", pht_wr_cnt, exp_cnt);
        end
        chk("resolve_err", resolve_err, m_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned pat;
        bit          b;
        n_checks = 0;
        n_fail   = 0;
        m_ghr    = 0;
        m_err    = 1'b0;
        reset_n          = 1'b0;
        f_branch_valid   = 1'b0;
        f_pc             = '0;
        pht_rd_cnt       = 2'b01;
        ex_resolve_valid = 1'b0;
        ex_taken         = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy_init", busy_init, 1);
        chk("rst f_stall", f_stall, 1);
        chk("rst pht_wr_en", pht_wr_en, 0);
        chk("rst ex_mispredict", ex_mispredict, 0);
        chk("rst resolve_err", resolve_err, 0);

        // Full PHT clear; fetch keeps offering a taken-predicted branch which must be ignored.
        f_branch_valid = 1'b1;
        f_pc           = 32'h0000_0ab4;
        pht_rd_cnt     = 2'b11;
        reset_n        = 1'b1;
        for (int k = 0; k < PHT_SIZE; k++) begin
            @(posedge clk);
            #1;
            chk("init wr_en", pht_wr_en, 1);
            chk("init wr_idx", pht_wr_idx, k);
            chk("init wr_cnt", pht_wr_cnt, 2'b01);
            chk("init f_stall", f_stall, 1);
        end
        f_branch_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("run busy_init", busy_init, 0);
        chk("run f_stall", f_stall, 0);
        chk("run wr_en", pht_wr_en, 0);

        // Single branch predicted not-taken, resolved taken.
        run_cycle(1'b1, 32'h100, 2'b01, 1'b0, 1'b0);
        run_cycle(1'b0, 32'h0, 2'b01, 1'b1, 1'b1);
        chk("t2 wr_idx", pht_wr_idx, 32'h040);
        chk("t2 wr_cnt", pht_wr_cnt, 2'b10);
        chk("t2 mispredict", ex_mispredict, 1);
        chk("t2 ghr", pht_rd_idx, 32'h001);

        // Fill the queue, then push+pop while full: the push is blocked.
        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        run_cycle(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1, mq[0].pred);
        run_cycle(1'b0, $urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        while (mq.size() > 0)
            run_cycle(1'b0, $urandom, 2'($urandom_range(0, 3)), 1'b1, mq[0].pred);

        // Counter saturation at both ends.
        run_cycle(1'b1, 32'h2000, 2'b11, 1'b0, 1'b0);
        run_cycle(1'b0, 32'h2000, 2'b11, 1'b1, 1'b1);
        chk("t5 sat hi", pht_wr_cnt, 2'b11);
        run_cycle(1'b1, 32'h3004, 2'b00, 1'b0, 1'b0);
        run_cycle(1'b0, 32'h3004, 2'b00, 1'b1, 1'b0);
        chk("t5 sat lo", pht_wr_cnt, 2'b00);
        chk("t5 no mispredict", ex_mispredict, 0);

        // Steer history to 0x005, queue preds 0,1,1, then mispredict the head while pushing.
        pat = 32'h005;
        for (int i = GHR_BITS - 1; i >= 0; i--) begin
            b = 1'((pat >> i) & 1);
            if (mq.size() > 0)
                run_cycle(1'b1, $urandom, b ? 2'b10 : 2'b01, 1'b1, mq[0].pred);
            else
                run_cycle(1'b1, $urandom, b ? 2'b10 : 2'b01, 1'b0, 1'b0);
        end
        run_cycle(1'b0, 32'h0, 2'b01, 1'b1, mq[0].pred);
        run_cycle(1'b1, 32'h0, 2'b01, 1'b0, 1'b0);
        run_cycle(1'b1, 32'h44, 2'b10, 1'b0, 1'b0);
        run_cycle(1'b1, 32'h88, 2'b11, 1'b0, 1'b0);
        run_cycle(1'b1, 32'hcc, 2'b11, 1'b1, 1'b1);
        f_pc             = '0;
        f_branch_valid   = 1'b0;
        ex_resolve_valid = 1'b0;
        #1;
        chk("t4 ghr", pht_rd_idx, 32'h00B);
        chk("t4 f_stall", f_stall, 0);

        // Resolve with nothing in flight.
        run_cycle(1'b0, 32'h0, 2'b01, 1'b1, 1'b0);
        chk("t6 resolve_err", resolve_err, 1);

        repeat (400) begin
            bit rv, tk;
            rv = ($urandom_range(0, 9) < 4);
            tk = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) tk = mq[0].pred;
            run_cycle($urandom_range(0, 9) < 7, $urandom, 2'($urandom_range(0, 3)), rv, tk);
        end

        // Reset in the middle of RUN with branches in flight.
        run_cycle(1'b1, $urandom, 2'b10, 1'b0, 1'b0);
        reset_n          = 1'b0;
        f_pc             = '0;
        f_branch_valid   = 1'b0;
        ex_resolve_valid = 1'b0;
        #1;
        chk("mid rst busy_init", busy_init, 1);
        chk("mid rst f_stall", f_stall, 1);
        chk("mid rst wr_en", pht_wr_en, 0);
        chk("mid rst mispredict", ex_mispredict, 0);
        chk("mid rst resolve_err", resolve_err, 0);
        chk("mid rst ghr", pht_rd_idx, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("reinit wr_en", pht_wr_en, 1);
            chk("reinit wr_idx", pht_wr_idx, k);
        end
        ex_resolve_valid = 1'b1;
        ex_taken         = 1'b1;
        @(posedge clk);
        #1;
        ex_resolve_valid = 1'b0;
        chk("init resolve_err", resolve_err, 1);
        chk("init resolve no misp", ex_mispredict, 0);
        chk("init resolve wr_idx", pht_wr_idx, 8);
        chk("init resolve wr_cnt", pht_wr_cnt, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
